// File: rtl/alu_op_sequencer.sv
// ALU control for the single-cycle RV32 core: decodes class/func3/func7 into
// the ALU opcode and flags illegal ops. RV32M ops are launched on an
// external multi-cycle MDU (start/done handshake) while the core stalls.
// Optional macro ALU_SEQ_STALL_CNT_EN adds a saturating stall_cycles counter.
// Ports:
//   clk, rst (async, active-high)
//   instr_valid, op_class[7:0] {auipc,lui,jal,branch,load,store,i_type,r_type}
//   func3[2:0], func7[6:0], flush, mdu_done
//   alu_op[OPW-1:0], mdu_start, mdu_op[2:0], stall, mdu_busy,
//   mdu_timeout, illegal, stall_cycles[CNT_W-1:0] (macro only)
module alu_op_sequencer #(
  parameter int OPW         = 5,
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [7:0]       op_class,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             flush,
  input  logic             mdu_done,
  output logic [OPW-1:0]   alu_op,
  output logic             mdu_start,
  output logic [2:0]       mdu_op,
  output logic             stall,
  output logic             mdu_busy,
  output logic             mdu_timeout,
  output logic             illegal
`ifdef ALU_SEQ_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  localparam int TW = $clog2(MDU_TIMEOUT + 1);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SLL  = OPW'(1);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(2);
  localparam logic [OPW-1:0] OP_SLTU = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
  localparam logic [OPW-1:0] OP_SRL  = OPW'(5);
  localparam logic [OPW-1:0] OP_SRA  = OPW'(6);
  localparam logic [OPW-1:0] OP_OR   = OPW'(7);
  localparam logic [OPW-1:0] OP_AND  = OPW'(8);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(9);
  localparam logic [OPW-1:0] OP_PASS = OPW'(10);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]     state;
  logic [0:0]     nxt;
  logic [TW-1:0]  timer;
  logic [2:0]     mdu_op_q;
  logic [7:0]     cls;
  logic [OPW-1:0] dec_op;
  logic           dec_ill;
  logic           dec_mop;
  logic           mop;
  logic           tmo_hit;

  // Zero out a malformed class so the one-hot decoder sees no match.
  assign cls = ($onehot(op_class)) ? op_class : 8'h00;

  always_comb begin
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
    dec_mop = 1'b0;
    unique case (1'b1)
      cls[0]: begin
        if (func7 == 7'h00) begin
          case (func3)
            3'd0:    dec_op = OP_ADD;
            3'd1:    dec_op = OP_SLL;
            3'd2:    dec_op = OP_SLT;
            3'd3:    dec_op = OP_SLTU;
            3'd4:    dec_op = OP_XOR;
            3'd5:    dec_op = OP_SRL;
            3'd6:    dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end else if (func7 == 7'h20) begin
          if (func3 == 3'd0)      dec_op = OP_SUB;
          else if (func3 == 3'd5) dec_op = OP_SRA;
          else                    dec_ill = 1'b1;
        end else if (func7 == 7'h01) begin
          dec_mop = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      cls[1]: begin
        case (func3)
          3'd0: dec_op = OP_ADD;
          3'd1: begin
            if (func7 == 7'h00) dec_op = OP_SLL;
            else                dec_ill = 1'b1;
          end
          3'd2: dec_op = OP_SLT;
          3'd3: dec_op = OP_SLTU;
          3'd4: dec_op = OP_XOR;
          3'd5: begin
            if (func7 == 7'h00)      dec_op = OP_SRL;
            else if (func7 == 7'h20) dec_op = OP_SRA;
            else                     dec_ill = 1'b1;
          end
          3'd6:    dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
      end
      cls[4]: begin
        case (func3)
          3'd0, 3'd1: dec_op = OP_SUB;
          3'd4, 3'd5: dec_op = OP_SLT;
          3'd6, 3'd7: dec_op = OP_SLTU;
          default:    dec_ill = 1'b1;
        endcase
      end
      cls[6]:                         dec_op = OP_PASS;
      cls[2], cls[3], cls[5], cls[7]: dec_op = OP_ADD;
      default:                        dec_ill = 1'b1;
    endcase
  end

  assign illegal = instr_valid & dec_ill;
  assign mop     = instr_valid & dec_mop;
  assign alu_op  = (instr_valid & ~dec_ill & ~dec_mop) ? dec_op : OP_ADD;

  assign tmo_hit  = (timer == TW'(MDU_TIMEOUT));
  assign mdu_busy = (state == S_WAIT);
  assign mdu_op   = mdu_start ? func3 : mdu_op_q;

  // Outputs are gated by rst so an M-op held on the inputs during
  // reset cannot launch the MDU or stall the core.
  always_comb begin
    nxt         = state;
    mdu_start   = 1'b0;
    stall       = 1'b0;
    mdu_timeout = 1'b0;
    if (!rst) begin
      unique case (state)
        S_IDLE: begin
          if (mop && !flush) begin
            mdu_start = 1'b1;
            stall     = 1'b1;
            nxt       = S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) begin
            stall = 1'b1;
            nxt   = S_IDLE;
          end else if (mdu_done) begin
            nxt = S_IDLE;
          end else if (tmo_hit) begin
            mdu_timeout = 1'b1;
            nxt         = S_IDLE;
          end else begin
            stall = 1'b1;
          end
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      mdu_op_q <= 3'd0;
    end else begin
      state <= nxt;
      if (mdu_start) mdu_op_q <= func3;
      if (state == S_IDLE)
        timer <= mdu_start ? TW'(1) : '0;
      else if (nxt == S_IDLE)
        timer <= '0;
      else
        timer <= timer + 1'b1;
    end
  end

`ifdef ALU_SEQ_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (stall && !(&stall_cycles))
      stall_cycles <= stall_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed vectors push expected
// responses; a negedge monitor pops and compares.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [7:0]  op_class = 8'h00;
  logic [2:0]  func3 = 3'd0;
  logic [6:0]  func7 = 7'd0;
  logic        flush = 1'b0;
  logic        mdu_done = 1'b0;
  logic [4:0]  alu_op;
  logic        mdu_start;
  logic [2:0]  mdu_op;
  logic        stall;
  logic        mdu_busy;
  logic        mdu_timeout;
  logic        illegal;
`ifdef ALU_SEQ_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  alu_op_sequencer dut (
    .clk(clk),
    .rst(rst),
    .instr_valid(instr_valid),
    .op_class(op_class),
    .func3(func3),
    .func7(func7),
    .flush(flush),
    .mdu_done(mdu_done),
    .alu_op(alu_op),
    .mdu_start(mdu_start),
    .mdu_op(mdu_op),
    .stall(stall),
    .mdu_busy(mdu_busy),
    .mdu_timeout(mdu_timeout),
    .illegal(illegal)
`ifdef ALU_SEQ_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [7:0] R   = 8'h01;
  localparam logic [7:0] I   = 8'h02;
  localparam logic [7:0] ST  = 8'h04;
  localparam logic [7:0] LD  = 8'h08;
  localparam logic [7:0] BR  = 8'h10;
  localparam logic [7:0] JAL = 8'h20;
  localparam logic [7:0] LUI = 8'h40;
  localparam logic [7:0] AUI = 8'h80;

  // bits: [12:8] alu_op, 7 illegal, 6 start, 5 stall, 4 busy, 3 tmo, [2:0] mdu_op
  localparam logic [12:0] M_ALL = 13'h1FFF;
  localparam logic [12:0] M_NOP = 13'h1FF8;
  localparam logic [12:0] M_FLS = 13'h1FD8;

  typedef struct {
    string       nm;
    logic [12:0] v;
    logic [12:0] m;
    int          sc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [12:0] pk(input int aop, input bit ill,
                                     input bit st, input bit stl,
                                     input bit bsy, input bit tmo,
                                     input int mop);
    return {aop[4:0], ill, st, stl, bsy, tmo, mop[2:0]};
  endfunction

  task automatic cyc(input string nm, input logic r, input logic v,
                     input logic [7:0] c, input logic [2:0] f3,
                     input logic [6:0] f7, input logic fl,
                     input logic dn, input logic [12:0] ev,
                     input logic [12:0] em, input int sc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    instr_valid = v;
    op_class = c;
    func3 = f3;
    func7 = f7;
    flush = fl;
    mdu_done = dn;
    e.nm = nm;
    e.v = ev;
    e.m = em;
    e.sc = sc;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per cycle, checked mid-cycle.
  initial begin
    exp_t e;
    logic [12:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {alu_op, illegal, mdu_start, stall, mdu_busy,
               mdu_timeout, mdu_op};
        total++;
        if ((act & e.m) !== (e.v & e.m)) begin
          bad++;
          $display("FAIL %s: got %b want %b mask %b",
                   e.nm, act, e.v, e.m);
        end
`ifdef ALU_SEQ_STALL_CNT_EN
        if (e.sc >= 0) begin
          total++;
          if (stall_cycles !== 32'(e.sc)) begin
            bad++;
            $display("FAIL %s_cnt: got %0d want %0d",
                     e.nm, stall_cycles, e.sc);
          end
        end
`endif
      end
    end
  end

  initial begin
    // reset state, including an M-op presented while in reset
    cyc("rst0", 1, 0, 8'h00, 0, 7'h00, 0, 0, pk(0,0,0,0,0,0,0), M_ALL, 0);
    cyc("rst_mop", 1, 1, R, 0, 7'h01, 0, 0, pk(0,0,0,0,0,0,0), M_ALL, 0);
    // decoder
    cyc("r_add", 0, 1, R, 0, 7'h00, 0, 0, pk(0,0,0,0,0,0,0), M_NOP, -1);
    cyc("r_sub", 0, 1, R, 0, 7'h20, 0, 0, pk(9,0,0,0,0,0,0), M_NOP, -1);
    cyc("r_sra", 0, 1, R, 5, 7'h20, 0, 0, pk(6,0,0,0,0,0,0), M_NOP, -1);
    cyc("r_and", 0, 1, R, 7, 7'h00, 0, 0, pk(8,0,0,0,0,0,0), M_NOP, -1);
    cyc("r_sltu", 0, 1, R, 3, 7'h00, 0, 0, pk(3,0,0,0,0,0,0), M_NOP, -1);
    cyc("r_ill20", 0, 1, R, 1, 7'h20, 0, 0, pk(0,1,0,0,0,0,0), M_NOP, -1);
    cyc("r_ill10", 0, 1, R, 0, 7'h10, 0, 0, pk(0,1,0,0,0,0,0), M_NOP, -1);
    cyc("i_addneg", 0, 1, I, 0, 7'h20, 0, 0, pk(0,0,0,0,0,0,0), M_NOP, -1);
    cyc("i_slli", 0, 1, I, 1, 7'h00, 0, 0, pk(1,0,0,0,0,0,0), M_NOP, -1);
    cyc("i_slli_ill", 0, 1, I, 1, 7'h20, 0, 0, pk(0,1,0,0,0,0,0), M_NOP, -1);
    cyc("i_srli", 0, 1, I, 5, 7'h00, 0, 0, pk(5,0,0,0,0,0,0), M_NOP, -1);
    cyc("i_srai", 0, 1, I, 5, 7'h20, 0, 0, pk(6,0,0,0,0,0,0), M_NOP, -1);
    cyc("i_sri_ill", 0, 1, I, 5, 7'h01, 0, 0, pk(0,1,0,0,0,0,0), M_NOP, -1);
    cyc("i_ori", 0, 1, I, 6, 7'h7F, 0, 0, pk(7,0,0,0,0,0,0), M_NOP, -1);
    cyc("br_beq", 0, 1, BR, 0, 7'h00, 0, 0, pk(9,0,0,0,0,0,0), M_NOP, -1);
    cyc("br_bge", 0, 1, BR, 5, 7'h00, 0, 0, pk(2,0,0,0,0,0,0), M_NOP, -1);
    cyc("br_bltu", 0, 1, BR, 6, 7'h00, 0, 0, pk(3,0,0,0,0,0,0), M_NOP, -1);
    cyc("br_ill", 0, 1, BR, 2, 7'h00, 0, 0, pk(0,1,0,0,0,0,0), M_NOP, -1);
    cyc("lui", 0, 1, LUI, 3, 7'h55, 0, 0, pk(10,0,0,0,0,0,0), M_NOP, -1);
    cyc("load", 0, 1, LD, 2, 7'h7F, 0, 0, pk(0,0,0,0,0,0,0), M_NOP, -1);
    cyc("store", 0, 1, ST, 1, 7'h20, 0, 0, pk(0,0,0,0,0,0,0), M_NOP, -1);
    cyc("jal", 0, 1, JAL, 7, 7'h3F, 0, 0, pk(0,0,0,0,0,0,0), M_NOP, -1);
    cyc("auipc", 0, 1, AUI, 5, 7'h01, 0, 0, pk(0,0,0,0,0,0,0), M_NOP, -1);
    cyc("cls_none", 0, 1, 8'h00, 0, 7'h00, 0, 0, pk(0,1,0,0,0,0,0), M_NOP, -1);
    cyc("cls_two", 0, 1, 8'h03, 0, 7'h20, 0, 0, pk(0,1,0,0,0,0,0), M_NOP, -1);
    cyc("inv_sub", 0, 0, R, 0, 7'h20, 0, 0, pk(0,0,0,0,0,0,0), M_NOP, -1);
    cyc("inv_bad", 0, 0, BR, 2, 7'h00, 0, 0, pk(0,0,0,0,0,0,0), M_NOP, -1);
    // MUL: start cycle 0, done cycle 5
    cyc("mul_c0", 0, 1, R, 0, 7'h01, 0, 0, pk(0,0,1,1,0,0,0), M_ALL, -1);
    for (int k = 1; k <= 4; k++)
      cyc("mul_wait", 0, 1, R, 0, 7'h01, 0, 0, pk(0,0,0,1,1,0,0), M_ALL, -1);
    cyc("mul_done", 0, 1, R, 0, 7'h01, 0, 1, pk(0,0,0,0,1,0,0), M_ALL, -1);
    cyc("mul_idle", 0, 1, R, 0, 7'h00, 0, 0, pk(0,0,0,0,0,0,0), M_ALL, 5);
    cyc("done_idle", 0, 0, 8'h00, 0, 7'h00, 0, 1, pk(0,0,0,0,0,0,0), M_NOP, 5);
    cyc("after_done", 0, 0, 8'h00, 0, 7'h00, 0, 0, pk(0,0,0,0,0,0,0), M_NOP, 5);
    // back-to-back M-ops
    cyc("mulhu_st", 0, 1, R, 3, 7'h01, 0, 0, pk(0,0,1,1,0,0,3), M_ALL, -1);
    cyc("mulhu_dn", 0, 1, R, 3, 7'h01, 0, 1, pk(0,0,0,0,1,0,3), M_ALL, -1);
    cyc("rem_st", 0, 1, R, 6, 7'h01, 0, 0, pk(0,0,1,1,0,0,6), M_ALL, -1);
    cyc("rem_dn", 0, 1, R, 6, 7'h01, 0, 1, pk(0,0,0,0,1,0,6), M_ALL, -1);
    cyc("b2b_idle", 0, 0, 8'h00, 0, 7'h00, 0, 0, pk(0,0,0,0,0,0,0), M_NOP, -1);
    // flush: in IDLE blocks launch; in WAIT aborts without timeout
    cyc("fl_idle", 0, 1, R, 4, 7'h01, 1, 0, pk(0,0,0,0,0,0,0), M_NOP, -1);
    cyc("fl_idle2", 0, 0, 8'h00, 0, 7'h00, 0, 0, pk(0,0,0,0,0,0,0), M_NOP, -1);
    cyc("div_st", 0, 1, R, 4, 7'h01, 0, 0, pk(0,0,1,1,0,0,4), M_ALL, -1);
    cyc("div_w1", 0, 1, R, 4, 7'h01, 0, 0, pk(0,0,0,1,1,0,4), M_ALL, -1);
    cyc("div_w2", 0, 1, R, 4, 7'h01, 0, 0, pk(0,0,0,1,1,0,4), M_ALL, -1);
    cyc("div_fl", 0, 1, R, 4, 7'h01, 1, 0, pk(0,0,0,0,1,0,4), M_FLS, -1);
    cyc("fl_after", 0, 0, 8'h00, 0, 7'h00, 0, 0, pk(0,0,0,0,0,0,0), M_NOP, -1);
    // timeout at WAIT cycle 64, stray done afterwards ignored
    cyc("tmo_st", 0, 1, R, 5, 7'h01, 0, 0, pk(0,0,1,1,0,0,5), M_ALL, -1);
    for (int k = 1; k < 64; k++)
      cyc("tmo_wait", 0, 1, R, 5, 7'h01, 0, 0, pk(0,0,0,1,1,0,5), M_ALL, -1);
    cyc("tmo_hit", 0, 1, R, 5, 7'h01, 0, 0, pk(0,0,0,0,1,1,5), M_ALL, -1);
    cyc("tmo_stray", 0, 0, 8'h00, 0, 7'h00, 0, 1, pk(0,0,0,0,0,0,0), M_NOP, -1);
    cyc("tmo_idle", 0, 0, 8'h00, 0, 7'h00, 0, 0, pk(0,0,0,0,0,0,0), M_NOP, -1);
    // async reset while waiting
    cyc("rw_st", 0, 1, R, 2, 7'h01, 0, 0, pk(0,0,1,1,0,0,2), M_ALL, -1);
    cyc("rw_w1", 0, 1, R, 2, 7'h01, 0, 0, pk(0,0,0,1,1,0,2), M_ALL, -1);
    cyc("rw_rst", 1, 1, R, 2, 7'h01, 0, 0, pk(0,0,0,0,0,0,0), M_ALL, 0);
    cyc("rw_rst2", 1, 1, R, 2, 7'h01, 0, 0, pk(0,0,0,0,0,0,0), M_ALL, 0);
    cyc("rw_idle", 0, 0, 8'h00, 0, 7'h00, 0, 1, pk(0,0,0,0,0,0,0), M_ALL, 0);
    cyc("rw_end", 0, 1, I, 0, 7'h00, 0, 0, pk(0,0,0,0,0,0,0), M_ALL, -1);
    @(posedge clk);
    @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
